truth_table_sweeper: RTL and testbench

Self-check sequencer for the 5-input boolean function block and its three implementations: gate-level, dataflow and behavioural. On a start pulse it walks all 32 input vectors {A,B,C,D,G} in ascending order and drives each vector to all three implementations in parallel. It waits a programmable settle time, samples the three F outputs, records the behavioural result into a 32-bit truth table and flags any disagreement. It sits between the bench/top-level control and the three function instances, replacing hand-written per-vector stimulus.

---
 rtl/truth_table_sweeper.sv | 80 ++++++++
 tb/tb_truth_table_sweeper.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks all 32 {A,B,C,D,G} vectors through three F implementations,
// records the behavioural truth table and flags disagreements between them.
module truth_table_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  abcdg,
    input  logic        f_gate,
    input  logic        f_flow,
    input  logic        f_beh,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_table,
    output logic        mismatch,
    output logic [4:0]  first_bad,
    output logic [5:0]  err_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       bad;
    assign bad = !(f_gate == f_flow && f_flow == f_beh);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            abcdg       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            mismatch    <= 1'b0;
            first_bad   <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= DRIVE;
                    cnt         <= '0;
                    abcdg       <= '0;
                    busy        <= 1'b1;
                    truth_table <= '0;
                    mismatch    <= 1'b0;
                    first_bad   <= '0;
                    err_count   <= '0;
                end
                DRIVE: begin
                    cnt   <= cnt + 4'd1;
                    state <= (cnt == 4'(SETTLE - 1)) ? SAMPLE : DRIVE;
                end
                SAMPLE: begin
                    truth_table[abcdg] <= f_beh;
                    if (bad) begin
                        err_count <= err_count + 6'd1;
                        if (!mismatch) begin
                            mismatch  <= 1'b1;
                            first_bad <= abcdg;
                        end
                    end
                    // Vector 31 never wraps: it always leaves for DONE with abcdg held.
                    if (abcdg == 5'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        abcdg <= abcdg + 5'd1;
                        cnt   <= '0;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized fault-injection bench for truth_table_sweeper
// against a truth-table model computed directly from the injected fault masks.
module tb_truth_table_sweeper;
    logic        clk = 0, rst = 0, start2 = 0, start1 = 0;
    logic [4:0]  abcdg2, abcdg1, first_bad2, first_bad1;
    logic        busy2, busy1, done2, done1, mismatch2, mismatch1;
    logic [31:0] tbl2, tbl1;
    logic [5:0]  err_count2, err_count1;
    logic [31:0] gold = 32'hFAF7DF6B;
    logic [31:0] gmask = 0, fmask = 0, bmask = 0;
    logic        stuck = 0;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    wire f_gate2 = gold[abcdg2] ^ gmask[abcdg2];
    wire f_flow2 = stuck ? 1'b1 : gold[abcdg2] ^ fmask[abcdg2];
    wire f_beh2  = gold[abcdg2] ^ bmask[abcdg2];
    wire f_gate1 = gold[abcdg1] ^ gmask[abcdg1];
    wire f_flow1 = stuck ? 1'b1 : gold[abcdg1] ^ fmask[abcdg1];
    wire f_beh1  = gold[abcdg1] ^ bmask[abcdg1];

    truth_table_sweeper #(.SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abcdg(abcdg2),
        .f_gate(f_gate2), .f_flow(f_flow2), .f_beh(f_beh2),
        .busy(busy2), .done(done2), .truth_table(tbl2), .mismatch(mismatch2),
        .first_bad(first_bad2), .err_count(err_count2));
    truth_table_sweeper #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abcdg(abcdg1),
        .f_gate(f_gate1), .f_flow(f_flow1), .f_beh(f_beh1),
        .busy(busy1), .done(done1), .truth_table(tbl1), .mismatch(mismatch1),
        .first_bad(first_bad1), .err_count(err_count1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected results derived from which implementations are faulty at each vector.
    task automatic check_model(input string tag);
        logic [31:0] et = 0;
        int ec = 0, fb = -1;
        for (int v = 0; v < 32; v++) begin
            bit g = gold[v] ^ gmask[v];
            bit f = stuck ? 1'b1 : gold[v] ^ fmask[v];
            bit b = gold[v] ^ bmask[v];
            et[v] = b;
            if (!(g == f && f == b)) begin
                ec++;
                if (fb < 0) fb = v;
            end
        end
        check({tag, "_table"}, tbl2, et);
        check({tag, "_err_count"}, 32'(err_count2), 32'(ec));
        check({tag, "_mismatch"}, 32'(mismatch2), 32'(ec != 0));
        check({tag, "_first_bad"}, 32'(first_bad2), fb < 0 ? 0 : 32'(fb));
    endtask

    task automatic sweep2(input string tag, input int pulse_at);
        int n = 0;
        bit pulsed = 0;
        @(negedge clk) start2 = 1;
        @(posedge clk) #1;
        check({tag, "_busy_e0"}, 32'(busy2), 1);
        check({tag, "_abcdg_e0"}, 32'(abcdg2), 0);
        start2 = 0;
        do begin
            @(posedge clk) #1;
            n++;
            start2 = 0;
            if (pulse_at >= 0 && !pulsed && abcdg2 == 5'(pulse_at)) begin
                start2 = 1;
                pulsed = 1;
            end
        end while (!done2 && n < 2000);
        start2 = 0;
        check({tag, "_latency"}, 32'(n), 96);
        check({tag, "_busy_done"}, 32'(busy2), 0);
        check({tag, "_abcdg_done"}, 32'(abcdg2), 31);
        @(posedge clk) #1;
        check({tag, "_done_pulse"}, 32'(done2), 0);
    endtask

    initial begin
        int n;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        check("rst_abcdg", 32'(abcdg2), 0);
        check("rst_busy", 32'(busy2), 0);
        check("rst_done", 32'(done2), 0);
        check("rst_table", tbl2, 0);
        check("rst_mismatch", 32'(mismatch2), 0);
        check("rst_first_bad", 32'(first_bad2), 0);
        check("rst_err_count", 32'(err_count2), 0);

        sweep2("nominal", -1);
        check_model("nominal");
        check("nominal_gold", tbl2, 32'hFAF7DF6B);

        gmask = 32'h20;
        sweep2("gate5", -1);
        check_model("gate5");
        check("gate5_first_bad_lit", 32'(first_bad2), 5);
        gmask = 0;

        stuck = 1;
        sweep2("stuck", -1);
        check_model("stuck");
        check("stuck_err_lit", 32'(err_count2), 7);
        stuck = 0;

        sweep2("midstart", 10);
        check_model("midstart");

        // Abort mid-sweep with reset, then confirm a clean restart.
        gmask = 32'h1;
        @(negedge clk) start2 = 1;
        @(negedge clk) start2 = 0;
        n = 0;
        while (abcdg2 != 5'd10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach10", 32'(abcdg2), 10);
        rst = 1;
        #1;
        check("arst_abcdg", 32'(abcdg2), 0);
        check("arst_busy", 32'(busy2), 0);
        check("arst_table", tbl2, 0);
        check("arst_mismatch", 32'(mismatch2), 0);
        check("arst_err_count", 32'(err_count2), 0);
        check("arst_first_bad", 32'(first_bad2), 0);
        repeat (2) @(posedge clk);
        #1 check("arst_done", 32'(done2), 0);
        @(negedge clk) rst = 0;
        gmask = 0;
        repeat (3) @(posedge clk);
        #1 check("arst_no_done", 32'(done2), 0);
        sweep2("after_rst", -1);
        check_model("after_rst");

        for (int it = 0; it < 8; it++) begin
            gmask = $urandom & $urandom & $urandom;
            fmask = $urandom & $urandom & $urandom;
            bmask = $urandom & $urandom;
            stuck = ($urandom_range(0, 3) == 0);
            sweep2("rand", -1);
            check_model("rand");
        end
        gmask = 0; fmask = 0; bmask = 0; stuck = 0;

        // SETTLE=1 instance with start held high: back-to-back sweeps.
        @(negedge clk) start1 = 1;
        @(posedge clk) #1;
        check("s1_busy_e0", 32'(busy1), 1);
        n = 0;
        do begin
            @(posedge clk) #1;
            n++;
        end while (!done1 && n < 2000);
        check("s1_latency1", 32'(n), 64);
        check("s1_table1", tbl1, 32'hFAF7DF6B);
        @(posedge clk) #1;
        check("s1_idle_done", 32'(done1), 0);
        check("s1_idle_busy", 32'(busy1), 0);
        @(posedge clk) #1;
        check("s1_reaccept_busy", 32'(busy1), 1);
        check("s1_reaccept_table", tbl1, 0);
        check("s1_reaccept_abcdg", 32'(abcdg1), 0);
        n = 0;
        do begin
            @(posedge clk) #1;
            n++;
        end while (!done1 && n < 2000);
        check("s1_latency2", 32'(n), 64);
        check("s1_table2", tbl1, 32'hFAF7DF6B);
        check("s1_mismatch", 32'(mismatch1), 0);
        @(negedge clk) start1 = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
